regfile_dump: RTL and testbench

Debug read-out engine for the 32×32 register file. On a start request it walks register addresses 0..31 on one regfile read port, captures each combinational read value and streams it out over a valid/ready handshake, one register per beat. It sits beside the core's register file and is used by the debug/test harness to dump architectural state while the core is halted.

---
 rtl/regfile_dump.sv | 153 +++++++++++++++
 tb/tb_regfile_dump.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks regfile addresses 0..NREGS-1 and streams each value out over valid/ready.
// Optional trailing XOR checksum beat is built when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW-1:0] m_idx,
    output logic          m_last
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic [1:0] S_SUM  = 2'd3;
`endif
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [AW-1:0] m_idx_q, m_idx_d;
    logic          m_last_q, m_last_d;
    logic          done_q, done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DW-1:0] acc_q, acc_d;
`endif

    logic hs;
    assign hs = m_valid_q && m_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_idx_d   = m_idx_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                idx_d     = '0;
                m_valid_d = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            S_LOAD: begin
                // rd is sampled before any same-edge regfile write lands
                m_data_d  = rd;
                m_idx_d   = idx_q;
                m_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                m_last_d  = 1'b0;
                acc_d     = acc_q ^ rd;
`else
                m_last_d  = (idx_q == LAST_IDX);
`endif
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    m_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        state_d   = S_SUM;
                        m_valid_d = 1'b1;
                        m_data_d  = acc_q;
                        m_idx_d   = '0;
                        m_last_d  = 1'b1;
`else
                        state_d   = S_IDLE;
                        idx_d     = '0;
                        done_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_SUM: begin
                if (hs) begin
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    done_d    = 1'b1;
                end
            end
`endif
            default: begin
                state_d   = S_IDLE;
                idx_d     = '0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_idx_q   <= m_idx_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc_q     <= acc_d;
`endif
        end
    end

    // idx is forced to 0 whenever IDLE, so ra needs no extra gating
    assign ra      = idx_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_idx   = m_idx_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: random regfile contents and sink backpressure vs a snapshot model.
module tb_regfile_dump;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int DONE_LAT = 66;
`else
    localparam int DONE_LAT = 65;
`endif

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n, start, busy, done, m_valid, m_ready, m_last;
    logic [AW-1:0] ra, m_idx;
    logic [DW-1:0] rd, m_data;

    regfile_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .ra(ra), .rd(rd), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_idx(m_idx), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // regfile beside the DUT: combinational read, r0 hardwired to zero
    logic [DW-1:0] rf [NREGS];
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    always @(posedge clk) if (we) rf[wa] <= wd;
    assign rd = (ra == '0) ? '0 : rf[ra];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 0: always ready, 1: ready one cycle in three, 2: random, 3: never
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    // reference: a dump is a snapshot of the register values when it starts
    logic [DW-1:0] mdl [NREGS];
    beat_t exp_q[$];

    task automatic push_dump();
        beat_t b;
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < NREGS; i++) begin
            b.idx  = AW'(i);
            b.data = (i == 0) ? '0 : mdl[i];
            x      = x ^ b.data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == NREGS - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        b.idx = '0; b.data = x; b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // monitor: pops on every handshake, checks hold during stalls and done timing
    int            done_due = -1;
    logic          stall = 1'b0;
    logic [DW-1:0] p_data;
    logic [AW-1:0] p_idx;
    logic          p_last;
    always @(negedge clk) begin
        beat_t e;
        if (!reset_n) begin
            stall    = 1'b0;
            done_due = -1;
        end else begin
            if (done_due == cyc) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd0);
            end else if (done) begin
                chk("spurious_done", 32'(done), 32'd0);
            end
            if (stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", m_data, p_data);
                chk("stall_idx", 32'(m_idx), 32'(p_idx));
                chk("stall_last", 32'(m_last), 32'(p_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_idx", 32'(m_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_idx", 32'(m_idx), 32'(e.idx));
                    chk("beat_data", m_data, e.data);
                    chk("beat_last", 32'(m_last), 32'(e.last));
                    if (e.last) done_due = cyc + 1;
                end
            end
            stall  = m_valid && !m_ready;
            p_data = m_data;
            p_idx  = m_idx;
            p_last = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input int a, input logic [DW-1:0] d);
        we = 1'b1; wa = AW'(a); wd = d;
        tick();
        we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int k = 0; k < 1000; k++) begin
            if (done) begin
                c = cyc;
                break;
            end
            tick();
        end
        if (c < 0) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, c, found;
        reset_n = 1'b0; start = 1'b0; we = 1'b0; wa = '0; wd = '0;
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ra", 32'(ra), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_idx", 32'(m_idx), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < NREGS; i++) rf_write(i, (i == 0) ? 32'h0BAD_0000 : 32'h1000_0000 + 32'(i));

        // full dump, sink always ready: latency and done timing
        rdy_mode = 0;
        push_dump();
        pulse_start(s);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ra_after_start", 32'(ra), 32'd0);
        for (int k = 0; k < 10 && !m_valid; k++) tick();
        chk("first_valid_latency", 32'(cyc - s), 32'd2);
        wait_done(c);
        chk("done_latency", 32'(c - s), 32'(DONE_LAT));

        // same data, ready one cycle in three
        rdy_mode = 1;
        push_dump();
        pulse_start(s);
        wait_done(c);
        rdy_mode = 0;
        tick();

        // start held through the whole dump but dropped before the done cycle: one dump only
        push_dump();
        start = 1'b1;
        s = cyc;
        while (cyc < s + 64) tick();
        start = 1'b0;
        wait_done(c);
        chk("held_start_done_latency", 32'(c - s), 32'(DONE_LAT));
        for (int k = 0; k < 8; k++) tick();
        chk("no_second_dump", 32'(busy), 32'd0);

        // random start pulses while busy, random backpressure
        rdy_mode = 2;
        push_dump();
        pulse_start(s);
        for (int k = 0; k < 1000 && !done; k++) begin
            start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start = 1'b0;
        chk("random_start_done", 32'(done), 32'd1);
        rdy_mode = 0;
        for (int k = 0; k < 6; k++) tick();
        chk("random_start_idle", 32'(busy), 32'd0);

        // start still high in the done cycle: a second dump follows
        push_dump(); push_dump();
        start = 1'b1;
        wait_done(c);
        tick();
        start = 1'b0;
        chk("second_dump_busy", 32'(busy), 32'd1);
        wait_done(c);
        tick();

        // reset while SEND is stalled at idx 10
        rdy_mode = 1;
        push_dump();
        pulse_start(s);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (m_valid && m_idx == AW'(10)) begin found = 1; break; end
            tick();
        end
        chk("reach_idx10", 32'(found), 32'd1);
        reset_n = 1'b0;
        rdy_mode = 3;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ra", 32'(ra), 32'd0);
        chk("abort_data", m_data, 32'd0);
        chk("abort_idx", 32'(m_idx), 32'd0);
        chk("abort_last", 32'(m_last), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        rdy_mode = 0;
        push_dump();
        pulse_start(s);
        wait_done(c);
        chk("restart_done_latency", 32'(c - s), 32'(DONE_LAT));

        // random contents, random backpressure
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i < NREGS; i++) rf_write(i, $urandom);
            rdy_mode = 2;
            push_dump();
            pulse_start(s);
            wait_done(c);
            rdy_mode = 0;
            tick();
        end

        // write to r5 during its LOAD cycle: dump keeps the old value, next dump the new one
        rf_write(5, 32'h0505_0505);
        push_dump();
        pulse_start(s);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (busy && !m_valid && ra == AW'(5)) begin found = 1; break; end
            tick();
        end
        chk("reach_load5", 32'(found), 32'd1);
        rf_write(5, 32'hDEAD_BEEF);
        wait_done(c);
        tick();
        push_dump();
        pulse_start(s);
        wait_done(c);

        for (int k = 0; k < 4; k++) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
